// File: rtl/stopwatch_pkg.sv
// Shared stopwatch encodings and default cycle constants.
// Latency: n/a. Backpressure: n/a.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES   = 500000;
    localparam int unsigned DEF_LONG_PRESS_CYCLES = 50000000;
    localparam int unsigned DEF_TICK_CYCLES       = 500000;

    // Bits needed to hold the value n itself.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// Key conditioner: 2-FF sync, debounce counter, one-cycle press/release pulses.
// Latency: raw edge to pulse = DEBOUNCE_CYCLES+3 cycles. Backpressure: none.
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned W = cnt_width(DEBOUNCE_CYCLES);

    logic         sync1;
    logic         sync2;
    logic         level_q;
    logic [W-1:0] cnt;

    // Everything resets to the released (high) level so no event fires on reset exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            level         <= 1'b1;
            level_q       <= 1'b1;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            level_q       <= level;
            press_pulse   <= level_q & ~level;
            release_pulse <= ~level_q & level;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key conditioning, run/pause/idle FSM, 10 ms prescaler, freeze.
// Latency: press pulse to state/count_en 1 cycle; all outputs registered. Backpressure: none.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int unsigned TICK_CYCLES       = DEF_TICK_CYCLES
) (
    input  logic       clk,
    input  logic       key_reset,
    input  logic       key_start_pause,
    input  logic       key_display_stop,
    output logic       tick_10ms,
    output logic       count_en,
    output logic       disp_load,
    output logic       clear,
    output logic [1:0] state,
    output logic [3:0] led
);

    localparam int unsigned PW = cnt_width(TICK_CYCLES);
    localparam int unsigned HW = cnt_width(LONG_PRESS_CYCLES);

    logic          rst_n;
    logic          sp_level_unused, sp_press, sp_release;
    logic          dsp_level, dsp_press, dsp_release_unused;
    state_t        state_q, state_nxt;
    logic [PW-1:0] pcnt;
    logic [HW-1:0] hold_cnt;
    logic          hold_active;
    logic          freeze, freeze_nxt;
    logic          long_hit, tick_nxt;

    assign rst_n = key_reset;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sp (
        .clk(clk), .rst_n(rst_n), .key_raw(key_start_pause),
        .level(sp_level_unused), .press_pulse(sp_press), .release_pulse(sp_release)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dsp (
        .clk(clk), .rst_n(rst_n), .key_raw(key_display_stop),
        .level(dsp_level), .press_pulse(dsp_press), .release_pulse(dsp_release_unused)
    );

    always_comb begin
        state_nxt = state_q;
        long_hit  = 1'b0;
        case (state_q)
            ST_IDLE:  if (sp_press) state_nxt = ST_RUN;
            ST_RUN:   if (sp_press) state_nxt = ST_PAUSE;
            ST_PAUSE: begin
                // A release ends the hold before it can count as a long press.
                if (hold_active && sp_release) begin
                    state_nxt = ST_RUN;
                end else if (hold_active && hold_cnt == HW'(LONG_PRESS_CYCLES - 1)) begin
                    long_hit  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
        freeze_nxt = long_hit ? 1'b0 : (freeze ^ dsp_press);
        tick_nxt   = (pcnt == PW'(TICK_CYCLES - 1)) && !long_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pcnt        <= '0;
            hold_cnt    <= '0;
            hold_active <= 1'b0;
            freeze      <= 1'b0;
            tick_10ms   <= 1'b0;
            count_en    <= 1'b0;
            disp_load   <= 1'b0;
            clear       <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pcnt    <= (long_hit || pcnt == PW'(TICK_CYCLES - 1)) ? '0 : pcnt + 1'b1;
            if (state_nxt != ST_PAUSE) begin
                hold_active <= 1'b0;
                hold_cnt    <= '0;
            end else if (state_q == ST_PAUSE && !hold_active && sp_press) begin
                hold_active <= 1'b1;
                hold_cnt    <= HW'(1);
            end else if (hold_active && hold_cnt != HW'(LONG_PRESS_CYCLES)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            freeze    <= freeze_nxt;
            tick_10ms <= tick_nxt;
            count_en  <= (state_nxt == ST_RUN);
            // Clear also loads the display so it shows the zeroed timer.
            disp_load <= (tick_nxt && !freeze_nxt) || long_hit;
            clear     <= long_hit;
        end
    end

    assign state = state_q;
    assign led   = {hold_active, count_en, freeze, ~dsp_level};

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with small cycle constants.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int D = 4;
    localparam int L = 20;
    localparam int T = 5;

    logic       clk = 1'b0;
    logic       key_reset, key_start_pause, key_display_stop;
    logic       tick_10ms, count_en, disp_load, clear;
    logic [1:0] state;
    logic [3:0] led;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .TICK_CYCLES(T)
    ) dut (
        .clk(clk), .key_reset(key_reset), .key_start_pause(key_start_pause),
        .key_display_stop(key_display_stop), .tick_10ms(tick_10ms), .count_en(count_en),
        .disp_load(disp_load), .clear(clear), .state(state), .led(led)
    );

    int total = 0;
    int bad   = 0;
    int n;

    // Reference model: cycle-stamped arithmetic over key samples and events.
    logic [1:0] raw_q[$];
    logic [1:0] m_lvl, m_pend_p, m_pend_r, m_vis_p, m_vis_r;
    int         m_ref[2];
    int         m_mode;   // 0 idle, 1 run, 2 pause
    bit         m_hold, m_frz, m_tick, m_dl, m_clr;
    int         m_hold_t, m_z;

    // Observations for directed checks.
    int   cen_rise, clr_at, dl_cnt, first_tick;
    logic prev_cen, clr_dl;

    task automatic model_init();
        raw_q    = '{2'b11, 2'b11};
        m_lvl    = 2'b11;
        m_ref    = '{0, 0};
        m_pend_p = '0; m_pend_r = '0; m_vis_p = '0; m_vis_r = '0;
        m_mode   = 0;
        m_hold   = 0; m_frz = 0; m_tick = 0; m_dl = 0; m_clr = 0;
        m_hold_t = 0; m_z = 0; n = 0;
        prev_cen = 0; first_tick = -1;
    endtask

    task automatic model_edge(input logic sp, input logic dsp);
        logic [1:0] s, p_now, r_now;
        n++;
        p_now    = m_vis_p;
        r_now    = m_vis_r;
        s        = raw_q.pop_front();
        raw_q.push_back({dsp, sp});
        m_vis_p  = m_pend_p;
        m_vis_r  = m_pend_r;
        m_pend_p = '0;
        m_pend_r = '0;
        for (int k = 0; k < 2; k++) begin
            if (s[k] == m_lvl[k]) begin
                m_ref[k] = n;
            end else if (n - m_ref[k] == D) begin
                m_lvl[k] = s[k];
                m_ref[k] = n;
                if (s[k] == 1'b0) m_pend_p[k] = 1'b1;
                else              m_pend_r[k] = 1'b1;
            end
        end
        m_clr = 0;
        case (m_mode)
            0: if (p_now[0]) m_mode = 1;
            1: if (p_now[0]) m_mode = 2;
            default: begin
                if (m_hold && r_now[0]) begin
                    m_mode = 1; m_hold = 0;
                end else if (m_hold && n - m_hold_t == L) begin
                    m_clr = 1; m_mode = 0; m_hold = 0;
                end else if (!m_hold && p_now[0]) begin
                    m_hold = 1; m_hold_t = n - 1;
                end
            end
        endcase
        if (m_clr)         m_frz = 0;
        else if (p_now[1]) m_frz = !m_frz;
        if (m_clr) begin
            m_z    = n;
            m_tick = 0;
        end else begin
            m_tick = ((n - m_z) % T == 0);
        end
        m_dl = (m_tick && !m_frz) || m_clr;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [9:0] g, e;
        g = {tick_10ms, count_en, disp_load, clear, state, led};
        e = {m_tick, (m_mode == 1), m_dl, m_clr, 2'(m_mode), m_hold, (m_mode == 1), m_frz, ~m_lvl[1]};
        total++;
        assert (g === e) else begin
            bad++;
            $error("FAIL outputs cyc=%0d got=%b exp=%b", n, g, e);
        end
    endtask

    task automatic cyc(input logic sp, input logic dsp);
        key_start_pause  = sp;
        key_display_stop = dsp;
        @(posedge clk);
        model_edge(sp, dsp);
        @(negedge clk);
        check_outputs();
        if (count_en && !prev_cen) cen_rise = n;
        prev_cen = count_en;
        if (clear) begin
            clr_at = n;
            clr_dl = disp_load;
        end
        if (disp_load) dl_cnt++;
        if (tick_10ms && first_tick < 0) first_tick = n;
    endtask

    task automatic run(input logic sp, input logic dsp, input int cycles);
        repeat (cycles) cyc(sp, dsp);
    endtask

    initial begin
        int f;
        key_reset        = 1'b0;
        key_start_pause  = 1'b1;
        key_display_stop = 1'b1;
        model_init();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {22'd0, tick_10ms, count_en, disp_load, clear, state, led}, 32'd0);
        key_reset = 1'b1;
        model_init();

        // Idle ticking
        dl_cnt = 0;
        run(1, 1, 50);
        chk("idle_disp_loads", dl_cnt, 10);
        chk("idle_first_tick", first_tick, T);

        // Start: press to count_en latency
        f = n;
        run(0, 1, 10); run(1, 1, 10);
        chk("cen_latency", cen_rise - f, D + 4);
        chk("state_run", state, ST_RUN);

        // Freeze while running, then unfreeze
        run(1, 0, 10); run(1, 1, 10);
        chk("frozen_led", led[1], 1);
        dl_cnt = 0;
        run(1, 1, 25);
        chk("frozen_no_load", dl_cnt, 0);
        chk("frozen_counting", count_en, 1);
        run(1, 0, 10); run(1, 1, 10);
        dl_cnt = 0;
        run(1, 1, 25);
        chk("unfrozen_loads", dl_cnt, 5);

        // Pause, short hold resumes, pause again
        run(0, 1, 10); run(1, 1, 10);
        chk("state_pause", state, ST_PAUSE);
        chk("pause_cen", count_en, 0);
        run(0, 1, 10); run(1, 1, 10);
        chk("short_hold_run", state, ST_RUN);
        run(0, 1, 10); run(1, 1, 10);
        run(1, 0, 10); run(1, 1, 10);
        chk("refrozen_led", led[1], 1);

        // Long press clears
        f = n; clr_at = -1; clr_dl = 0;
        run(0, 1, 30);
        chk("clear_latency", clr_at - f, D + 3 + L);
        chk("clear_disp_load", clr_dl, 1);
        run(1, 1, 15);
        chk("long_idle", state, ST_IDLE);
        chk("long_unfrozen", led[1], 0);

        // Short glitches are ignored
        run(0, 1, 2); run(1, 1, 10);
        run(1, 0, 2); run(1, 1, 10);
        chk("glitch_state", state, ST_IDLE);
        chk("glitch_freeze", led[1], 0);

        // Random key activity
        for (int seg = 0; seg < 40; seg++) begin
            run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 30));
        end

        // Async reset mid-hold with freeze set
        @(negedge clk);
        key_reset = 1'b0;
        key_start_pause = 1'b1; key_display_stop = 1'b1;
        repeat (2) @(negedge clk);
        key_reset = 1'b1;
        model_init();
        run(0, 1, 10); run(1, 1, 10);
        run(1, 0, 10); run(1, 1, 10);
        run(0, 1, 10); run(1, 1, 10);
        run(0, 1, 15);
        chk("prereset_led", led, 4'b1010);
        chk("prereset_state", state, ST_PAUSE);
        #2;
        key_reset = 1'b0;
        #1;
        chk("async_reset_outputs", {22'd0, tick_10ms, count_en, disp_load, clear, state, led}, 32'd0);
        @(negedge clk);
        key_start_pause = 1'b1;
        key_reset = 1'b1;
        model_init();
        run(1, 1, 12);
        chk("post_reset_first_tick", first_tick, T);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
